// File: rtl/wr_first_edge_bram_pkg.sv
// Shared parameters and types for the per-core first-edge BRAM read and write stages.
package wr_first_edge_bram_pkg;

    localparam int FE_V_ID_WIDTH      = 32;
    localparam int FE_BRAM_AWIDTH     = 11;
    localparam int FE_BRAM_DWIDTH     = 32;
    localparam int FE_CORE_NUM        = 16;
    localparam int FE_CORE_NUM_WIDTH  = 4;

    // Total number of vertices the per-core BRAMs can hold together.
    localparam int unsigned FE_CAPACITY = FE_CORE_NUM << FE_BRAM_AWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fe_wr_state_e;

endpackage

// File: rtl/wr_first_edge_bram_first_edge_wr_port.sv
// One core's registered BRAM write port; addr/data only update when this core is selected.
module first_edge_wr_port #(
    parameter int AWIDTH = 11,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] data,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [DWIDTH-1:0] wr_data,
    output logic              wr_en
);

    logic [AWIDTH-1:0] addr_d, addr_q;
    logic [DWIDTH-1:0] data_d, data_q;
    logic              en_d, en_q;

    // Next-state: capture the write when selected, otherwise hold addr/data.
    always_comb begin
        en_d   = sel;
        addr_d = addr_q;
        data_d = data_q;
        if (sel) begin
            addr_d = addr;
            data_d = data;
        end else begin
            addr_d = addr_q;
            data_d = data_q;
        end
    end

    // Write port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            data_q <= '0;
            en_q   <= 1'b0;
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
            en_q   <= en_d;
        end
    end

    assign wr_addr = addr_q;
    assign wr_data = data_q;
    assign wr_en   = en_q;

endmodule

// File: rtl/wr_first_edge_bram.sv
// Loads first-edge offsets into per-core BRAMs: vertex v goes to core v % CORE_NUM, address v / CORE_NUM.
module wr_first_edge_bram
    import wr_first_edge_bram_pkg::*;
#(
    parameter int V_ID_WIDTH             = FE_V_ID_WIDTH,
    parameter int FIRST_EDGE_BRAM_AWIDTH = FE_BRAM_AWIDTH,
    parameter int FIRST_EDGE_BRAM_DWIDTH = FE_BRAM_DWIDTH,
    parameter int CORE_NUM               = FE_CORE_NUM,
    parameter int CORE_NUM_WIDTH         = FE_CORE_NUM_WIDTH
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    input  logic [V_ID_WIDTH-1:0]                      vertex_num,
    input  logic [FIRST_EDGE_BRAM_DWIDTH-1:0]          front_first_edge,
    input  logic                                       front_first_edge_valid,
    output logic                                       stage_full,
    output logic [CORE_NUM*FIRST_EDGE_BRAM_AWIDTH-1:0] wr_edge_addr,
    output logic [CORE_NUM*FIRST_EDGE_BRAM_DWIDTH-1:0] wr_edge_data,
    output logic [CORE_NUM-1:0]                        wr_edge_en,
    output logic                                       load_busy,
    output logic                                       load_done,
    output logic                                       load_error
);

    localparam int AW = FIRST_EDGE_BRAM_AWIDTH;
    localparam int DW = FIRST_EDGE_BRAM_DWIDTH;
    // One extra bit so the capacity itself is representable for any V_ID_WIDTH.
    localparam logic [V_ID_WIDTH:0] CAPACITY = (V_ID_WIDTH+1)'(CORE_NUM) << AW;

    fe_wr_state_e          state_d, state_q;
    logic [V_ID_WIDTH-1:0] v_cnt_d, v_cnt_q;
    logic [V_ID_WIDTH-1:0] vnum_d, vnum_q;
    logic                  err_d, err_q;

    logic                  accept_s;
    logic                  too_big_s;
    logic [CORE_NUM-1:0]   core_sel_s;
    logic [AW-1:0]         wr_addr_s;

    assign stage_full = (state_q != ST_LOAD);
    assign accept_s   = front_first_edge_valid && !stage_full;
    assign too_big_s  = ({1'b0, vertex_num} > CAPACITY);
    assign wr_addr_s  = AW'(v_cnt_q >> CORE_NUM_WIDTH);

    // One-hot core select for the entry being accepted this cycle.
    always_comb begin
        core_sel_s = '0;
        if (accept_s) begin
            core_sel_s = CORE_NUM'(1) << v_cnt_q[CORE_NUM_WIDTH-1:0];
        end else begin
            core_sel_s = '0;
        end
    end

    // Load FSM, vertex counter and error flag next-state.
    always_comb begin
        state_d = state_q;
        v_cnt_d = v_cnt_q;
        vnum_d  = vnum_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (vertex_num == V_ID_WIDTH'(0)) begin
                        state_d = ST_DONE;
                        err_d   = 1'b0;
                    end else if (too_big_s) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                        v_cnt_d = '0;
                        vnum_d  = vertex_num;
                        err_d   = 1'b0;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    v_cnt_d = v_cnt_q + V_ID_WIDTH'(1);
                    if (v_cnt_q == vnum_q - V_ID_WIDTH'(1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            v_cnt_q <= '0;
            vnum_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            v_cnt_q <= v_cnt_d;
            vnum_q  <= vnum_d;
            err_q   <= err_d;
        end
    end

    assign load_busy  = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign load_done  = (state_q == ST_DONE);
    assign load_error = err_q;

    for (genvar i = 0; i < CORE_NUM; i++) begin : g_port
        first_edge_wr_port #(
            .AWIDTH (AW),
            .DWIDTH (DW)
        ) u_port (
            .clk     (clk),
            .rst_n   (rst_n),
            .sel     (core_sel_s[i]),
            .addr    (wr_addr_s),
            .data    (front_first_edge),
            .wr_addr (wr_edge_addr[i*AW +: AW]),
            .wr_data (wr_edge_data[i*DW +: DW]),
            .wr_en   (wr_edge_en[i])
        );
    end

endmodule

// File: tb/tb_wr_first_edge_bram.sv
// Directed, table-driven bench for wr_first_edge_bram with a write-capturing monitor.
module tb_wr_first_edge_bram;

    localparam int VW = 32;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int CN = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [VW-1:0]    vertex_num = '0;
    logic [DW-1:0]    front_first_edge = '0;
    logic             front_first_edge_valid = 1'b0;
    logic             stage_full;
    logic [CN*AW-1:0] wr_edge_addr;
    logic [CN*DW-1:0] wr_edge_data;
    logic [CN-1:0]    wr_edge_en;
    logic             load_busy, load_done, load_error;

    wr_first_edge_bram dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vertex_num(vertex_num),
        .front_first_edge(front_first_edge), .front_first_edge_valid(front_first_edge_valid),
        .stage_full(stage_full), .wr_edge_addr(wr_edge_addr), .wr_edge_data(wr_edge_data),
        .wr_edge_en(wr_edge_en), .load_busy(load_busy), .load_done(load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int multi_en = 0;
    int wcore[$];
    int waddr[$];
    int wdata[$];
    int wcyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every write pulse seen mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            int n;
            n = 0;
            for (int i = 0; i < CN; i++) begin
                if (wr_edge_en[i]) begin
                    n++;
                    wcore.push_back(i);
                    waddr.push_back(int'(wr_edge_addr[i*AW +: AW]));
                    wdata.push_back(int'(wr_edge_data[i*DW +: DW]));
                    wcyc.push_back(cyc);
                end
            end
            if (n > 1) multi_en++;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wcore.delete(); waddr.delete(); wdata.delete(); wcyc.delete();
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk); #1;
        start = 1'b1;
        vertex_num = VW'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Streams n offsets base+k; gapped inserts an idle cycle before each entry.
    task automatic stream(input int n, input int base, input bit gapped, input int inj_at);
        for (int k = 0; k < n; k++) begin
            if (gapped) begin
                front_first_edge_valid = 1'b0;
                @(posedge clk); #1;
            end
            front_first_edge = DW'(base + k);
            front_first_edge_valid = 1'b1;
            if (k == inj_at) begin
                start = 1'b1;
                vertex_num = VW'(5);
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        front_first_edge_valid = 1'b0;
    endtask

    typedef struct {
        int k;
        int core;
        int addr;
        int data;
    } exp_t;

    exp_t tbl[6];

    task automatic check_table(input string tag);
        for (int i = 0; i < 6; i++) begin
            int k;
            k = tbl[i].k;
            if (k < wcore.size()) begin
                check($sformatf("%s_v%0d_core", tag, k), wcore[k], tbl[i].core);
                check($sformatf("%s_v%0d_addr", tag, k), waddr[k], tbl[i].addr);
                check($sformatf("%s_v%0d_data", tag, k), wdata[k], tbl[i].data);
            end else begin
                check($sformatf("%s_v%0d_missing", tag, k), wcore.size(), k + 1);
            end
        end
    endtask

    initial begin
        tbl[0] = '{0, 0, 0, 100};
        tbl[1] = '{3, 3, 0, 103};
        tbl[2] = '{15, 15, 0, 115};
        tbl[3] = '{16, 0, 1, 116};
        tbl[4] = '{17, 1, 1, 117};
        tbl[5] = '{19, 3, 1, 119};

        // Reset and idle
        rst_n = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_stage_full", stage_full, 1);
        check("rst_en", wr_edge_en, 0);
        check("rst_done", load_done, 0);
        check("rst_busy", load_busy, 0);
        check("rst_error", load_error, 0);
        check("rst_addr_zero", (wr_edge_addr == '0), 1);
        check("rst_data_zero", (wr_edge_data == '0), 1);
        @(posedge clk); #1;
        front_first_edge = DW'(55);
        front_first_edge_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 front_first_edge_valid = 1'b0;
        @(negedge clk);
        check("idle_valid_no_writes", wcore.size(), 0);

        // Continuous load of 20
        clear_log();
        pulse_start(20);
        check("start_stage_full", stage_full, 0);
        check("start_busy", load_busy, 1);
        stream(20, 100, 1'b0, -1);
        @(negedge clk);
        check("cont_done_after1", load_done, 0);
        check("cont_busy_drain", load_busy, 1);
        @(negedge clk);
        check("cont_done_after2", load_done, 1);
        check("cont_busy_done", load_busy, 0);
        check("cont_nwrites", wcore.size(), 20);
        check_table("cont");

        // Gapped load of 20 from DONE
        clear_log();
        pulse_start(20);
        stream(20, 100, 1'b1, -1);
        repeat (3) @(negedge clk);
        check("gap_done", load_done, 1);
        check("gap_nwrites", wcore.size(), 20);
        check_table("gap");
        for (int k = 1; k < wcyc.size(); k++)
            check($sformatf("gap_spacing_%0d", k), wcyc[k] - wcyc[k-1], 2);

        // Zero-length start
        clear_log();
        pulse_start(0);
        @(negedge clk);
        check("zero_done", load_done, 1);
        check("zero_error", load_error, 0);
        check("zero_busy", load_busy, 0);
        front_first_edge_valid = 1'b1;
        repeat (2) @(negedge clk);
        front_first_edge_valid = 1'b0;
        check("zero_no_writes", wcore.size(), 0);

        // Capacity + 1
        pulse_start(32769);
        @(negedge clk);
        check("over_done", load_done, 1);
        check("over_error", load_error, 1);
        repeat (2) @(negedge clk);
        check("over_error_held", load_error, 1);
        check("over_no_writes", wcore.size(), 0);

        // Exactly capacity
        clear_log();
        pulse_start(32768);
        check("cap_error_cleared", load_error, 0);
        check("cap_busy", load_busy, 1);
        stream(32768, 5000, 1'b0, -1);
        repeat (2) @(negedge clk);
        check("cap_done", load_done, 1);
        check("cap_nwrites", wcore.size(), 32768);
        if (wcore.size() > 0) begin
            check("cap_last_core", wcore[wcore.size()-1], 15);
            check("cap_last_addr", waddr[waddr.size()-1], 2047);
            check("cap_last_data", wdata[wdata.size()-1], 37767);
        end else begin
            check("cap_last_missing", 0, 1);
        end

        // Reset mid-load
        clear_log();
        pulse_start(10);
        stream(5, 200, 1'b0, -1);
        check("mid_en_before_rst", wr_edge_en, 16);
        rst_n = 1'b0;
        #1;
        check("mid_rst_en", wr_edge_en, 0);
        check("mid_rst_stage_full", stage_full, 1);
        check("mid_rst_busy", load_busy, 0);
        check("mid_rst_data_zero", (wr_edge_data == '0), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_log();
        pulse_start(3);
        stream(3, 300, 1'b0, -1);
        repeat (2) @(negedge clk);
        check("restart_done", load_done, 1);
        check("restart_nwrites", wcore.size(), 3);
        for (int k = 0; k < 3 && k < wcore.size(); k++) begin
            check($sformatf("restart_core_%0d", k), wcore[k], k);
            check($sformatf("restart_addr_%0d", k), waddr[k], 0);
            check($sformatf("restart_data_%0d", k), wdata[k], 300 + k);
        end

        // Start ignored while loading
        clear_log();
        pulse_start(10);
        stream(10, 400, 1'b0, 3);
        @(negedge clk);
        check("ign_busy_drain", load_busy, 1);
        @(negedge clk);
        check("ign_done", load_done, 1);
        check("ign_nwrites", wcore.size(), 10);
        if (wcore.size() == 10) begin
            check("ign_last_core", wcore[9], 9);
            check("ign_last_data", wdata[9], 409);
        end else begin
            check("ign_last_missing", wcore.size(), 10);
        end

        check("single_hot_en", multi_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wr_first_edge_bram.md
# wr_first_edge_bram

Write-side counterpart of the per-core first-edge BRAM read stage. Before an iteration starts, it takes a stream of first-edge offsets, one per vertex in ascending vertex-ID order. Vertex v goes to core `v % CORE_NUM`, and each offset is written to that core's first-edge BRAM port at address `v / CORE_NUM`. It reports load completion to the control logic that launches iterations.

## Interface
- `V_ID_WIDTH`, 32: vertex ID width; also the width of `vertex_num`.
- `FIRST_EDGE_BRAM_AWIDTH`, 11: per-core BRAM address width.
- `FIRST_EDGE_BRAM_DWIDTH`, 32: first-edge offset width.
- `CORE_NUM`, 16: number of cores; must be a power of two.
- `CORE_NUM_WIDTH`, 4: log2(`CORE_NUM`).

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load.
- `vertex_num`  in  V_ID_WIDTH  number of vertices to load; sampled when `start` is accepted.
- `front_first_edge`  in  FIRST_EDGE_BRAM_DWIDTH  offset for the next vertex.
- `front_first_edge_valid`  in  1  `front_first_edge` is valid.
- `stage_full`  out  1  backpressure; the block accepts no entry while this is 1.
- `wr_edge_addr`  out  CORE_NUM*FIRST_EDGE_BRAM_AWIDTH  per-core BRAM write address.
- `wr_edge_data`  out  CORE_NUM*FIRST_EDGE_BRAM_DWIDTH  per-core BRAM write data.
- `wr_edge_en`  out  CORE_NUM  per-core write enable.
- `load_busy`  out  1  high in LOAD or DRAIN.
- `load_done`  out  1  high in DONE; level signal.
- `load_error`  out  1  `vertex_num` exceeded capacity; level signal held in DONE.

## Operation
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE or DONE, `start`=1:
  - `vertex_num`=0 → DONE.
  - `vertex_num` > CORE_NUM·2^AWIDTH → DONE with `load_error`=1.
  - Otherwise → LOAD. Clear `v_cnt`, latch `vertex_num`, clear `load_error`.
- `start` in LOAD or DRAIN is ignored.
- Accept condition: `front_first_edge_valid && !stage_full`.
- `stage_full` = (state != LOAD), decoded from the state register.
- Valid entries presented outside LOAD are not consumed and produce no writes.
- On accept:
  - core = `v_cnt[CORE_NUM_WIDTH-1:0]`; addr = `v_cnt >> CORE_NUM_WIDTH`, truncated to AWIDTH.
  - Register the write for that core only.
  - Increment `v_cnt` (V_ID_WIDTH bits; capacity check guarantees no wrap).
- Accept with `v_cnt == vertex_num-1` → DRAIN. DRAIN → DONE unconditionally.
- Write outputs for non-enabled cores hold their previous values. Only `wr_edge_en` is meaningful.
- Reset mid-operation:
  - All state clears immediately and the FSM returns to IDLE.
  - BRAM contents already written are not cleared; consumers must reload.

## Timing
- Reset values:
  - `stage_full`=1.
  - `wr_edge_en`, `load_busy`, `load_done`, `load_error` = 0.
  - `wr_edge_addr`, `wr_edge_data` = 0.
- Start latency: `start` at cycle N → LOAD at N+1 (`stage_full`=0, `load_busy`=1).
- Write latency: accept at cycle N → `wr_edge_en[core]` is a one-cycle pulse at N+1, with addr and data valid in the same cycle.
- Throughput: one entry per cycle, sustained.
- Completion: last accept at N → write pulse and DRAIN at N+1 → DONE at N+2 (`load_done`=1, `load_busy`=0).
- Zero-length or error `start` at N → DONE at N+1, with no writes.
- `load_done` and `load_error` stay asserted until the next accepted `start` or reset.

## Structure
- Shared package holds:
  - The capacity constant CORE_NUM<<FIRST_EDGE_BRAM_AWIDTH.
  - The FSM state enum.
  - Defaults shared with the read stage (`V_ID_WIDTH`, `FIRST_EDGE_BRAM_*`, `CORE_NUM*`).
- One sub-module, `first_edge_wr_port`, generated per core. It holds the registered addr/data/en for that core, enabled by a one-hot core select.
- The top level holds the FSM, `v_cnt`, and the capacity compare.

## Test plan
- Reset and idle behaviour:
  - Hold `rst_n`=0 for 10 cycles, release, and keep inputs idle for 1 cycle → `stage_full`=1, all `wr_edge_en`=0, `load_done`=0, `load_busy`=0, `load_error`=0.
  - Then present valid=1 with no `start` for 3 cycles → no writes.
- Continuous load:
  - Pulse `start` with `vertex_num`=20, then stream offsets 100+k continuously.
  - Vertex 17 → only `wr_edge_en[1]`, addr 1, data 117.
  - Vertex 3 → `wr_edge_en[3]`, addr 0, data 103.
  - `load_done`=1 exactly 2 cycles after the 20th accept.
- Gapped stream:
  - Same load as above with valid toggled every other cycle → identical writes, and no `wr_edge_en` in cycles following a non-accept.
- Boundary `vertex_num` values:
  - `vertex_num`=0 → `load_done`=1 at cycle N+1, no writes.
  - `vertex_num`=32769 (capacity+1) → `load_done`=1 and `load_error`=1 at N+1, no writes.
  - `vertex_num`=32768 → final write goes to core 15, addr 2047.
- Reset mid-load:
  - Assert `rst_n`=0 after 5 accepts → outputs reset without a clock edge.
  - Restart with `vertex_num`=3 → writes go to cores 0, 1, 2 at addr 0.
- Ignored `start`:
  - Pulse `start` with `vertex_num`=5 during LOAD of 10 → ignored; exactly 10 writes occur, then `load_done`=1.
